// File: rtl/g_macro_pkg.sv
// Shared definitions for the schematic macro library blocks.
package g_macro_pkg;

   localparam int NREQ = 4;   // requesters per arbiter
   localparam int HCW  = 8;   // hold-counter width

   // Arbiter ownership state
   typedef enum logic {
      IDLE = 1'b0,
      OWN  = 1'b1
   } state_t;

endpackage : g_macro_pkg

// File: rtl/g_4rrarb_if.sv
// Request/grant bundle of the four-way round-robin arbiter.
// Handshake: REQ[i] is a level; the arbiter answers with a registered one-hot
// GNT one edge later and keeps it while REQ[GID] stays high, up to MAXHOLD
// cycles. Dropping REQ[GID] releases the grant; GNT is all-zero for at least
// one cycle between owners. CE qualifies every register update.
interface g_4rrarb_if;
   import g_macro_pkg::*;

   logic                 CE;
   logic [NREQ-1:0]      REQ;
   logic [NREQ-1:0]      GNT;
   logic [1:0]           GID;
   logic                 ANY;
   logic                 TOUT;
   state_t               STATE;   // debug view of the ownership FSM
   logic [HCW-1:0]       HC;      // debug view of the hold counter

   // Requester side
   modport master (
      output CE, REQ,
      input  GNT, GID, ANY, TOUT, STATE, HC
   );

   // Arbiter side
   modport slave (
      input  CE, REQ,
      output GNT, GID, ANY, TOUT, STATE, HC
   );

endinterface : g_4rrarb_if

// File: rtl/g_4rrarb_pick.sv
// Round-robin pick: rotate requests so LAST+1 sits at bit 0, select the lowest
// set bit, then rotate the index back.
module g_4rrarb_pick
   import g_macro_pkg::*;
(
   input  logic [NREQ-1:0] REQ,
   input  logic [1:0]      LAST,
   output logic [1:0]      PICK,
   output logic            VALID
);

   logic [NREQ-1:0] rot;
   logic [1:0]      sel;

   // Rotate: rot[i] is the request i+1 positions after LAST
   always_comb begin
      rot = '0;
      for (int i = 0; i < NREQ; i++) begin
         rot[i] = REQ[LAST + 2'(i + 1)];
      end
   end

   // Fixed priority on the rotated vector, lowest index wins
   always_comb begin
      sel = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (rot[i]) begin
            sel = 2'(i);
         end
      end
   end

   assign PICK  = LAST + 2'd1 + sel;
   assign VALID = |REQ;

endmodule : g_4rrarb_pick

// File: rtl/g_4rrarb.sv
// Four-way round-robin arbiter with bounded hold time and a one-cycle idle
// gap between owners. ANY is the registered OR of the requests.
module g_4rrarb
   import g_macro_pkg::*;
#(
   parameter int MAXHOLD = 16   // 1..255, 0 = unlimited hold
)(
   input  logic       CK,
   input  logic       CD,
   g_4rrarb_if.slave  bus
);

   if (MAXHOLD < 0 || MAXHOLD > 255) begin : g_bad_maxhold
      $error("g_4rrarb: MAXHOLD must be in 0..255");
   end

   localparam bit             LIMITED = (MAXHOLD != 0);
   localparam logic [HCW-1:0] MAX_HC  = HCW'(MAXHOLD);

   state_t          state, state_n;
   logic [NREQ-1:0] gnt, gnt_n;
   logic [1:0]      gid, gid_n;
   logic [1:0]      last, last_n;
   logic [HCW-1:0]  hc, hc_n;
   logic            tout, tout_n;
   logic            any;
   logic [1:0]      pick;
   logic            pick_valid;

   g_4rrarb_pick u_pick (
      .REQ   (bus.REQ),
      .LAST  (last),
      .PICK  (pick),
      .VALID (pick_valid)
   );

   // Register all state; CE=0 freezes everything but clears the TOUT pulse
   always_ff @(posedge CK or posedge CD) begin
      if (CD) begin
         state <= IDLE;
         gnt   <= '0;
         gid   <= 2'd0;
         last  <= 2'd3;
         hc    <= '0;
         tout  <= 1'b0;
         any   <= 1'b0;
      end else if (bus.CE) begin
         state <= state_n;
         gnt   <= gnt_n;
         gid   <= gid_n;
         last  <= last_n;
         hc    <= hc_n;
         tout  <= tout_n;
         any   <= |bus.REQ;
      end else begin
         tout  <= 1'b0;
      end
   end

   // Next-state: grant from IDLE, then release, expire or keep counting in OWN
   always_comb begin
      state_n = state;
      gnt_n   = gnt;
      gid_n   = gid;
      last_n  = last;
      hc_n    = hc;
      tout_n  = 1'b0;
      case (state)
         IDLE: begin
            if (pick_valid) begin
               gnt_n   = 4'b0001 << pick;
               gid_n   = pick;
               last_n  = pick;
               hc_n    = 8'd1;
               state_n = OWN;
            end
         end
         OWN: begin
            if (!bus.REQ[gid]) begin
               // release wins over a coincident expiry
               gnt_n   = '0;
               state_n = IDLE;
            end else if (LIMITED && hc == MAX_HC) begin
               gnt_n   = '0;
               tout_n  = 1'b1;
               state_n = IDLE;
            end else if (hc != 8'hFF) begin
               hc_n    = hc + 8'd1;
            end
         end
         default: begin
            state_n = IDLE;
            gnt_n   = '0;
         end
      endcase
   end

   assign bus.GNT   = gnt;
   assign bus.GID   = gid;
   assign bus.ANY   = any;
   assign bus.TOUT  = tout;
   assign bus.STATE = state;
   assign bus.HC    = hc;

endmodule : g_4rrarb

// File: doc/g_4rrarb.md
Name: g_4rrarb

Overview:
- Four-way round-robin arbiter that shares one downstream resource among requesters REQ[3:0].
- Sits in the schematic macro library next to the basic gates; ANY is the registered 4-input OR of the requests and feeds downstream enable logic.
- Enforces a bounded hold time and a one-cycle idle gap between owners so mux selects can switch cleanly.

Parameters:
- MAXHOLD, 16: maximum consecutive cycles one owner may hold GNT. Legal range 1..255; 0 means unlimited.

Ports:
- CK    in   1  rising-edge clock
- CD    in   1  asynchronous clear, active high
- CE    in   1  clock enable; when low, state holds
- REQ   in   4  request lines, one per requester; level-sensitive
- GNT   out  4  one-hot grant, registered; all-zero when no owner
- GID   out  2  index of current or most recent owner, registered
- ANY   out  1  registered OR of REQ[3:0]
- TOUT  out  1  one-cycle pulse when a grant is revoked by MAXHOLD expiry

Behaviour:
- Reset (CD=1, asynchronous, effective immediately, including mid-ownership):
  - GNT=0000, GID=00, ANY=0, TOUT=0.
  - State=IDLE, LAST=3, hold counter HC=0.
  - REQ[0] therefore has top priority after reset.
- All registers update only on CK rising edges with CE=1.
- CE=0: every register holds, except TOUT, which is forced 0 on the next edge.
- ANY is REQ[0]|REQ[1]|REQ[2]|REQ[3], registered; latency 1 cycle.
- State IDLE (GNT=0000):
  - If any REQ is high, pick the first asserted index scanning LAST+1, LAST+2, LAST+3, LAST (mod 4).
  - Next edge: GNT=onehot(pick), GID=pick, LAST=pick, HC=1, state=OWN.
  - Latency from REQ to GNT is 1 cycle.
  - With no REQ high: stay in IDLE; GID holds.
- State OWN (GNT=onehot(GID)):
  - Release: REQ[GID]=0 at an edge. Next: GNT=0000, state=IDLE, TOUT=0.
  - Expiry: MAXHOLD!=0, HC==MAXHOLD, REQ[GID] still 1. Next: GNT=0000, TOUT=1 for one cycle, state=IDLE.
  - Otherwise: HC=HC+1, saturating at 255; GNT unchanged.
  - Release and expiry in the same cycle: treat as release, TOUT=0.
- Resulting timing rules:
  - GNT is high for at most MAXHOLD cycles.
  - At least one all-zero GNT cycle separates any two grants, including back-to-back grants to the same requester.
  - Requests from non-owners are ignored during OWN; they are evaluated in the IDLE gap cycle.
  - A timed-out owner becomes LAST, so it has lowest priority at the next pick.
- GNT is always one-hot or zero; GID is stable while GNT is non-zero.
- HC is 8 bits; MAXHOLD>255 is illegal; a simulation-time assertion flags it.

Decomposition:
- Shared package g_macro_pkg:
  - NREQ=4.
  - State encodings IDLE=1'b0, OWN=1'b1.
  - HCW=8.
- One combinational sub-module, g_4rrarb_pick:
  - Inputs REQ[3:0] and LAST[1:0].
  - Outputs PICK[1:0] and VALID.
  - Implements rotate, fixed-priority select, un-rotate.
- The top level holds the FSM, HC, LAST, ANY and TOUT registers.

Test Plan:
- Reset and priority:
  - Stimulus: CD pulse; then REQ=1111 held, MAXHOLD=4.
  - Required: GNT sequence 0001×4, 0000, 0010×4, 0000, 0100×4, 0000, 1000×4, 0000, then repeats.
  - Required: TOUT pulses once after each 4-cycle grant.
- Release:
  - Stimulus: REQ=0100 for 3 cycles, then 0000.
  - Required: GNT=0100 from cycle 1 to cycle 3, 0000 at cycle 4; GID=10 throughout; TOUT never asserts.
- Simultaneous release and expiry:
  - Stimulus: MAXHOLD=2, REQ[1] drops on the same edge HC==2.
  - Required: GNT→0000, TOUT=0.
- Rotation fairness:
  - Stimulus: LAST=1 (after a grant to 1); REQ=1001 in the IDLE cycle.
  - Required: grant goes to 3 (scan order 2,3,0,1), GID=11.
- CE freeze:
  - Stimulus: CE=0 for 5 cycles mid-OWN.
  - Required: GNT, GID, HC and ANY hold; TOUT stays 0; ownership resumes counting when CE=1.
- Async reset mid-ownership:
  - Stimulus: CD asserted between edges while GNT=1000.
  - Required: GNT=0000 and ANY=0 immediately, without a clock edge; after CD drops, REQ=1000 is granted with LAST=3 priority order (0 first).
